// File: rtl/apb4_master_bridge_pkg.sv
// Shared types and widths for the APB4 requester bridge.
package apb4_master_bridge_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned PROT_WIDTH = 3;

    // Encoding is visible on the debug port, keep values stable.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    // Request fields latched on accept and driven onto the APB bus.
    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] strb;
        logic [PROT_WIDTH-1:0] prot;
    } apb_req_t;

endpackage

// File: rtl/apb4_master_bridge_if.sv
// Requester-side and APB-side signals of the bridge, grouped with modports.
interface apb4_master_bridge_if;
    import apb4_master_bridge_pkg::*;

    logic                  transfer;
    logic                  SWRITE;
    logic [ADDR_WIDTH-1:0] SADDR;
    logic [DATA_WIDTH-1:0] SWDATA;
    logic [STRB_WIDTH-1:0] SSTRB;
    logic [PROT_WIDTH-1:0] SPROT;
    logic                  SREADY;
    logic [DATA_WIDTH-1:0] SRDATA;
    logic                  SDONE;
    logic                  SERR;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [STRB_WIDTH-1:0] PSTRB;
    logic [PROT_WIDTH-1:0] PPROT;
    logic                  PREADY;
    logic                  PSLVERR;
    logic [DATA_WIDTH-1:0] PRDATA;

    modport master (
        input  transfer, SWRITE, SADDR, SWDATA, SSTRB, SPROT,
        input  PREADY, PSLVERR, PRDATA,
        output SREADY, SRDATA, SDONE, SERR,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
    );

    modport slave (
        output transfer, SWRITE, SADDR, SWDATA, SSTRB, SPROT,
        output PREADY, PSLVERR, PRDATA,
        input  SREADY, SRDATA, SDONE, SERR,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
    );

endinterface

// File: rtl/apb4_master_bridge_wait_timer.sv
// Counts ACCESS wait states; expired flags the last allowed wait cycle (never when TIMEOUT_CYCLES=0).
module apb4_master_bridge_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (count_q == LIMIT);

endmodule

// File: rtl/apb4_master_bridge.sv
// APB4 requester: turns single-cycle requests into SETUP/ACCESS transfers with wait-state timeout.
module apb4_master_bridge
    import apb4_master_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    apb4_master_bridge_if.master bus,
    output state_e              cs
);

    state_e                state_q, state_d;
    apb_req_t              req_q, req_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  sdone_q, sdone_d;
    logic                  serr_q, serr_d;
    logic [DATA_WIDTH-1:0] srdata_q, srdata_d;
    logic                  sready_c;
    logic                  accept;
    logic                  expired;

    assign sready_c = (state_q == IDLE) || ((state_q == ACCESS) && bus.PREADY);
    assign accept   = bus.transfer && sready_c;

    apb4_master_bridge_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (PCLK),
        .rst_n  (PRESETn),
        .clear  (state_q == SETUP),
        .inc    ((state_q == ACCESS) && !bus.PREADY),
        .expired(expired)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        sdone_d   = 1'b0;
        serr_d    = 1'b0;
        srdata_d  = srdata_q;

        unique case (state_q)
            IDLE: begin
                if (accept) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    sdone_d = 1'b1;
                    serr_d  = bus.PSLVERR;
                    if (!req_q.write) srdata_d = bus.PRDATA;
                    state_d = accept ? SETUP : IDLE;
                end else if (expired) begin
                    sdone_d = 1'b1;
                    serr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Read strobes are forced low on the bus.
        if (accept) begin
            req_d.write = bus.SWRITE;
            req_d.addr  = bus.SADDR;
            req_d.wdata = bus.SWDATA;
            req_d.strb  = bus.SWRITE ? bus.SSTRB : STRB_WIDTH'(0);
            req_d.prot  = bus.SPROT;
        end

        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            req_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            sdone_q   <= 1'b0;
            serr_q    <= 1'b0;
            srdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            sdone_q   <= sdone_d;
            serr_q    <= serr_d;
            srdata_q  <= srdata_d;
        end
    end

    assign bus.SREADY  = sready_c;
    assign bus.SRDATA  = srdata_q;
    assign bus.SDONE   = sdone_q;
    assign bus.SERR    = serr_q;
    assign bus.PSEL    = psel_q;
    assign bus.PENABLE = penable_q;
    assign bus.PWRITE  = req_q.write;
    assign bus.PADDR   = req_q.addr;
    assign bus.PWDATA  = req_q.wdata;
    assign bus.PSTRB   = req_q.strb;
    assign bus.PPROT   = req_q.prot;
    assign cs          = state_q;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Directed self-checking bench for apb4_master_bridge; outputs sampled on the falling edge.
module tb_apb4_master_bridge;
    import apb4_master_bridge_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_e cs;
    int     checks = 0;
    int     errors = 0;

    apb4_master_bridge_if bus();

    apb4_master_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .PCLK   (clk),
        .PRESETn(rst_n),
        .bus    (bus),
        .cs     (cs)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1);
    end

    task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [2:0] prot);
        bus.transfer = 1'b1;
        bus.SWRITE   = wr;
        bus.SADDR    = addr;
        bus.SWDATA   = data;
        bus.SSTRB    = strb;
        bus.SPROT    = prot;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.transfer = 1'b0; bus.SWRITE = 1'b0; bus.SADDR = '0; bus.SWDATA = '0;
        bus.SSTRB = '0; bus.SPROT = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = '0;
        @(negedge clk);
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.SDONE, bus.SERR, bus.SREADY} !== 5'b00001) begin
            errors++; $display("FAIL reset_ctrl: got %b exp 00001",
                {bus.PSEL, bus.PENABLE, bus.SDONE, bus.SERR, bus.SREADY});
        end
        checks++;
        if ({bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB, bus.PPROT, bus.SRDATA} !== '0) begin
            errors++; $display("FAIL reset_data: got addr %h wdata %h srdata %h exp 0",
                bus.PADDR, bus.PWDATA, bus.SRDATA);
        end
        checks++;
        if (cs !== IDLE) begin errors++; $display("FAIL reset_state: got %0d exp %0d", cs, IDLE); end
    endtask

    // Reset release and first request on the same edge.
    task automatic test_write();
        rst_n = 1'b1;
        bus.PREADY = 1'b1;
        drive_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010);
        @(negedge clk);
        bus.transfer = 1'b0;
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.SREADY, bus.SDONE} !== 5'b10100 || cs !== SETUP) begin
            errors++; $display("FAIL write_setup: got %b cs %0d exp 10100 cs 1",
                {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.SREADY, bus.SDONE}, cs);
        end
        checks++;
        if ({bus.PADDR, bus.PWDATA, bus.PSTRB, bus.PPROT} !== {32'h10, 32'hDEADBEEF, 4'hF, 3'b010}) begin
            errors++; $display("FAIL write_fields: got %h %h %h %h exp 10 deadbeef f 2",
                bus.PADDR, bus.PWDATA, bus.PSTRB, bus.PPROT);
        end
        @(negedge clk);
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.SREADY, bus.SDONE} !== 4'b1110 || cs !== ACCESS
            || bus.PADDR !== 32'h10 || bus.PSTRB !== 4'hF) begin
            errors++; $display("FAIL write_access: got %b cs %0d addr %h exp 1110 cs 2 addr 10",
                {bus.PSEL, bus.PENABLE, bus.SREADY, bus.SDONE}, cs, bus.PADDR);
        end
        @(negedge clk);
        checks++;
        if ({bus.SDONE, bus.SERR, bus.PSEL, bus.PENABLE} !== 4'b1000 || cs !== IDLE
            || bus.SRDATA !== 32'h0 || bus.PADDR !== 32'h10) begin
            errors++; $display("FAIL write_done: got %b cs %0d srdata %h addr %h exp 1000 cs 0 srdata 0 addr 10",
                {bus.SDONE, bus.SERR, bus.PSEL, bus.PENABLE}, cs, bus.SRDATA, bus.PADDR);
        end
        @(negedge clk);
        checks++;
        if (bus.SDONE !== 1'b0) begin errors++; $display("FAIL write_pulse: got %b exp 0", bus.SDONE); end
    endtask

    task automatic test_read_wait();
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'hCAFEF00D;
        drive_req(1'b0, 32'h20, 32'h12345678, 4'hF, 3'b000);
        @(negedge clk);
        bus.transfer = 1'b0;
        checks++;
        if (cs !== SETUP || bus.PSTRB !== 4'h0 || bus.PWRITE !== 1'b0 || bus.PADDR !== 32'h20) begin
            errors++; $display("FAIL read_setup: got cs %0d strb %h wr %b addr %h exp cs 1 strb 0 wr 0 addr 20",
                cs, bus.PSTRB, bus.PWRITE, bus.PADDR);
        end
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (cs !== ACCESS || {bus.PSEL, bus.PENABLE, bus.SREADY, bus.SDONE} !== 4'b1100) begin
                errors++; $display("FAIL read_wait%0d: got cs %0d ctrl %b exp cs 2 ctrl 1100",
                    k, cs, {bus.PSEL, bus.PENABLE, bus.SREADY, bus.SDONE});
            end
        end
        bus.PREADY = 1'b1;
        @(negedge clk);
        bus.PRDATA = 32'h0;
        checks++;
        if ({bus.SDONE, bus.SERR, bus.PSEL} !== 3'b100 || bus.SRDATA !== 32'hCAFEF00D) begin
            errors++; $display("FAIL read_done: got %b srdata %h exp 100 srdata cafef00d",
                {bus.SDONE, bus.SERR, bus.PSEL}, bus.SRDATA);
        end
        @(negedge clk);
        checks++;
        if (bus.SRDATA !== 32'hCAFEF00D) begin
            errors++; $display("FAIL read_hold: got %h exp cafef00d", bus.SRDATA);
        end
    endtask

    task automatic test_back_to_back();
        bus.PREADY = 1'b1;
        drive_req(1'b1, 32'h04, 32'h11111111, 4'h3, 3'b001);
        @(negedge clk);
        drive_req(1'b0, 32'h08, 32'h22222222, 4'hF, 3'b000);
        bus.PRDATA = 32'hA5A5A5A5;
        checks++;
        if (cs !== SETUP || bus.PADDR !== 32'h04) begin
            errors++; $display("FAIL b2b_setup1: got cs %0d addr %h exp cs 1 addr 04", cs, bus.PADDR);
        end
        @(negedge clk);
        checks++;
        if (cs !== ACCESS || bus.PADDR !== 32'h04 || bus.PSTRB !== 4'h3 || bus.SREADY !== 1'b1) begin
            errors++; $display("FAIL b2b_access1: got cs %0d addr %h strb %h srdy %b exp cs 2 addr 04 strb 3 srdy 1",
                cs, bus.PADDR, bus.PSTRB, bus.SREADY);
        end
        @(negedge clk);
        bus.transfer = 1'b0;
        bus.PRDATA = 32'h0BADC0DE;
        checks++;
        if (cs !== SETUP || {bus.PSEL, bus.PENABLE, bus.SDONE, bus.SERR} !== 4'b1010
            || {bus.PADDR, bus.PWRITE, bus.PSTRB} !== {32'h08, 1'b0, 4'h0} || bus.SRDATA !== 32'hCAFEF00D) begin
            errors++; $display("FAIL b2b_setup2: got cs %0d ctrl %b addr %h srdata %h exp cs 1 ctrl 1010 addr 08 srdata cafef00d",
                cs, {bus.PSEL, bus.PENABLE, bus.SDONE, bus.SERR}, bus.PADDR, bus.SRDATA);
        end
        @(negedge clk);
        checks++;
        if (cs !== ACCESS || bus.SDONE !== 1'b0) begin
            errors++; $display("FAIL b2b_access2: got cs %0d done %b exp cs 2 done 0", cs, bus.SDONE);
        end
        @(negedge clk);
        checks++;
        if (cs !== IDLE || bus.SDONE !== 1'b1 || bus.SRDATA !== 32'h0BADC0DE) begin
            errors++; $display("FAIL b2b_done2: got cs %0d done %b srdata %h exp cs 0 done 1 srdata 0badc0de",
                cs, bus.SDONE, bus.SRDATA);
        end
    endtask

    task automatic test_slverr();
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b1;
        bus.PRDATA  = 32'h77777777;
        drive_req(1'b1, 32'h1C, 32'h55AA55AA, 4'hF, 3'b000);
        @(negedge clk);
        bus.transfer = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.PSLVERR = 1'b0;
        checks++;
        if ({bus.SDONE, bus.SERR} !== 2'b11 || bus.SRDATA !== 32'h0BADC0DE) begin
            errors++; $display("FAIL slverr_done: got %b srdata %h exp 11 srdata 0badc0de",
                {bus.SDONE, bus.SERR}, bus.SRDATA);
        end
        @(negedge clk);
        checks++;
        if ({bus.SDONE, bus.SERR} !== 2'b00) begin
            errors++; $display("FAIL slverr_clear: got %b exp 00", {bus.SDONE, bus.SERR});
        end
    endtask

    task automatic test_timeout();
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'hFFFF0000;
        drive_req(1'b0, 32'h30, 32'h0, 4'h0, 3'b000);
        @(negedge clk);
        bus.transfer = 1'b0;
        for (int k = 2; k <= 17; k++) begin
            @(negedge clk);
            checks++;
            if (cs !== ACCESS || bus.SDONE !== 1'b0 || bus.PSEL !== 1'b1) begin
                errors++; $display("FAIL timeout_wait%0d: got cs %0d done %b psel %b exp cs 2 done 0 psel 1",
                    k, cs, bus.SDONE, bus.PSEL);
            end
        end
        @(negedge clk);
        checks++;
        if (cs !== IDLE || {bus.PSEL, bus.PENABLE, bus.SDONE, bus.SERR} !== 4'b0011
            || bus.SRDATA !== 32'h0BADC0DE) begin
            errors++; $display("FAIL timeout_abort: got cs %0d ctrl %b srdata %h exp cs 0 ctrl 0011 srdata 0badc0de",
                cs, {bus.PSEL, bus.PENABLE, bus.SDONE, bus.SERR}, bus.SRDATA);
        end
    endtask

    task automatic test_reset_mid();
        bus.PREADY = 1'b0;
        drive_req(1'b1, 32'h40, 32'h99999999, 4'hF, 3'b000);
        @(negedge clk);
        bus.transfer = 1'b0;
        @(negedge clk);
        checks++;
        if (cs !== ACCESS) begin errors++; $display("FAIL rstmid_pre: got cs %0d exp 2", cs); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.SDONE, bus.SREADY} !== 4'b0001 || cs !== IDLE) begin
            errors++; $display("FAIL rstmid_async: got %b cs %0d exp 0001 cs 0",
                {bus.PSEL, bus.PENABLE, bus.SDONE, bus.SREADY}, cs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.PSEL, bus.SDONE, bus.SREADY} !== 3'b001 || cs !== IDLE || bus.PADDR !== 32'h0) begin
            errors++; $display("FAIL rstmid_release: got %b cs %0d addr %h exp 001 cs 0 addr 0",
                {bus.PSEL, bus.SDONE, bus.SREADY}, cs, bus.PADDR);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_back_to_back();
        test_slverr();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
